// File: rtl/i2s_tx_if.sv
// Sample stream into the I2S transmitter: a producer pushes PCM words with a valid/ready handshake.
interface i2s_tx_if #(
    parameter int WSZ = 24
) ();
    logic [WSZ-1:0] s_data;
    logic           s_valid;
    logic           s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers PCM words in a small FIFO and serialises them MSB-first with standard
// I2S framing (WS changes one SCK before the slot data), SCK derived from an external half-period tick.
module i2s_tx #(
    parameter int WSZ        = 24,
    parameter int SLOT       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            mode,
    input  logic                            tick,
    i2s_tx_if.slave                         s,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            underrun,
    output logic                            SCK,
    output logic                            WS,
    output logic                            SD
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(2 * SLOT);
    localparam logic [CW-1:0] LAST_CNT    = CW'(2 * SLOT - 1);
    localparam logic [CW-1:0] LEFT_LOAD   = CW'(1);
    localparam logic [CW-1:0] RIGHT_START = CW'(SLOT);
    localparam logic [CW-1:0] RIGHT_LOAD  = CW'(SLOT + 1);
    localparam logic [LW-1:0] DEPTH_L     = LW'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_next;
    logic [WSZ-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level, level_next;
    logic            ready_q;
    logic [CW-1:0]   bit_cnt, bit_cnt_next, cnt_inc;
    logic [SLOT-1:0] shift, shift_next;
    logic [WSZ-1:0]  hold, hold_next, load_word;
    logic            mono_q, mono_next;
    logic            sck_next, ws_next, sd_next, underrun_next;
    logic            push, pop, fifo_empty;

    assign push       = s.s_valid && ready_q;
    assign fifo_empty = (level == '0);
    assign s.s_ready  = ready_q;
    assign fifo_level = level;

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // Falling SCK edges advance the frame; slot loads pop the FIFO (or reuse the hold word in mono).
    always_comb begin
        state_next    = state;
        sck_next      = SCK;
        ws_next       = WS;
        sd_next       = SD;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        hold_next     = hold;
        mono_next     = mono_q;
        pop           = 1'b0;
        underrun_next = 1'b0;
        load_word     = '0;
        cnt_inc       = (bit_cnt == LAST_CNT) ? '0 : bit_cnt + CW'(1);
        case (state)
            IDLE: begin
                sck_next     = 1'b0;
                ws_next      = 1'b0;
                sd_next      = 1'b0;
                bit_cnt_next = '0;
                if (tick && en && !fifo_empty) begin
                    state_next = RUN;
                    sck_next   = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    if (!SCK) begin
                        sck_next = 1'b1;
                    end else if (bit_cnt == LAST_CNT && !en) begin
                        state_next   = IDLE;
                        sck_next     = 1'b0;
                        ws_next      = 1'b0;
                        sd_next      = 1'b0;
                        bit_cnt_next = '0;
                    end else begin
                        sck_next     = 1'b0;
                        bit_cnt_next = cnt_inc;
                        ws_next      = (cnt_inc >= RIGHT_START);
                        if (cnt_inc == LEFT_LOAD || cnt_inc == RIGHT_LOAD) begin
                            if (cnt_inc == RIGHT_LOAD && mono_q) begin
                                load_word = hold;
                            end else begin
                                if (cnt_inc == LEFT_LOAD) mono_next = mode;
                                if (fifo_empty) begin
                                    underrun_next = 1'b1;
                                end else begin
                                    pop       = 1'b1;
                                    load_word = mem[rd_ptr];
                                end
                                hold_next = load_word;
                            end
                            shift_next = '0;
                            shift_next[SLOT-1 -: WSZ] = load_word;
                        end else begin
                            shift_next = shift << 1;
                        end
                        sd_next = shift_next[SLOT-1];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready_q  <= 1'b1;
            bit_cnt  <= '0;
            shift    <= '0;
            hold     <= '0;
            mono_q   <= 1'b0;
            SCK      <= 1'b0;
            WS       <= 1'b0;
            SD       <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            level    <= level_next;
            ready_q  <= (level_next != DEPTH_L);
            bit_cnt  <= bit_cnt_next;
            shift    <= shift_next;
            hold     <= hold_next;
            mono_q   <= mono_next;
            SCK      <= sck_next;
            WS       <= ws_next;
            SD       <= sd_next;
            underrun <= underrun_next;
        end
    end

    // Storage has no reset; stale entries are never read because level gates every pop.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s.s_data;
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: captures SD/WS on every SCK rise and compares whole slots against
// hand-built expectations for stereo, mono, underrun, backpressure, mid-frame disable and reset.
module tb_i2s_tx;
    localparam int WSZ = 24, SLOT = 32, FIFO_DEPTH = 4, CAP = 4096;

    logic       clk = 1'b0;
    logic       rst, en, mode, tick;
    logic [2:0] fifo_level;
    logic       underrun, sck, ws, sd;

    i2s_tx_if #(.WSZ(WSZ)) bus ();

    i2s_tx #(.WSZ(WSZ), .SLOT(SLOT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .tick(tick), .s(bus),
        .fifo_level(fifo_level), .underrun(underrun), .SCK(sck), .WS(ws), .SD(sd)
    );

    always #5 clk = ~clk;

    int   assert_cnt = 0, fail_cnt = 0;
    int   rise_total = 0;
    logic sd_cap [CAP];
    logic ws_cap [CAP];
    int   under_cnt = 0, under_rise = -1;
    int   accept_cnt = 0, accept_rise = -1;

    initial begin
        int phase;
        phase = 0;
        tick  = 1'b0;
        forever begin
            @(negedge clk);
            tick  = (phase == 0);
            phase = (phase + 1) % 4;
        end
    end

    always @(posedge sck) begin
        if (rise_total < CAP) begin
            sd_cap[rise_total] <= sd;
            ws_cap[rise_total] <= ws;
        end
        rise_total <= rise_total + 1;
    end

    always @(negedge clk) begin
        if (underrun === 1'b1) begin
            under_cnt  = under_cnt + 1;
            under_rise = rise_total;
        end
    end

    always @(posedge clk) begin
        if (bus.s_valid && bus.s_ready) begin
            accept_cnt  <= accept_cnt + 1;
            accept_rise <= rise_total;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WSZ-1:0] w);
        bit done;
        done = 1'b0;
        bus.s_data  = w;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            if (bus.s_ready) done = 1'b1;
        end
        if (!done) checkOutput("push_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_rises(input int target);
        for (int i = 0; i < 4000 && rise_total < target; i++) @(negedge clk);
        if (rise_total < target) checkOutput("rise_timeout", 64'(rise_total), 64'(target));
    endtask

    function automatic logic [63:0] cap_bits(input int start, input int n, input bit use_ws);
        logic [63:0] val;
        val = '0;
        for (int i = 0; i < n; i++)
            val = {val[62:0], use_ws ? ws_cap[start + i] : sd_cap[start + i]};
        return val;
    endfunction

    task automatic run_one_frame(output int base, output int lvl_l, output int lvl_r);
        base = rise_total;
        en   = 1'b1;
        wait_rises(base + 2);
        lvl_l = int'(fifo_level);
        en    = 1'b0;
        wait_rises(base + 34);
        lvl_r = int'(fifo_level);
        wait_rises(base + 64);
        repeat (16) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        checkOutput({tag, "_sck"}, 64'(sck), 64'd0);
        checkOutput({tag, "_ws"},  64'(ws),  64'd0);
        checkOutput({tag, "_sd"},  64'(sd),  64'd0);
    endtask

    initial begin
        int base, base1, l1, l2, u0, a0;
        logic [WSZ-1:0] words [5];
        words = '{24'hDEADBE, 24'h0F1E2D, 24'hFFFFFF, 24'h000001, 24'h7A7A7A};
        rst = 1'b1; en = 1'b0; mode = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("por");
        checkOutput("por_ready", 64'(bus.s_ready), 64'd1);
        checkOutput("por_level", 64'(fifo_level), 64'd0);
        checkOutput("por_underrun", 64'(underrun), 64'd0);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(24'h13579B);
        base = rise_total;
        en   = 1'b1;
        wait_rises(base + 12);
        rst = 1'b1; en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        checkOutput("midrst_ready", 64'(bus.s_ready), 64'd1);
        checkOutput("midrst_level", 64'(fifo_level), 64'd0);
        checkOutput("midrst_underrun", 64'(underrun), 64'd0);

        $display("[TB] stereo frame");
        mode = 1'b0;
        applyStimulus(24'hA5F00F);
        applyStimulus(24'h123456);
        checkOutput("st_level_pre", 64'(fifo_level), 64'd2);
        u0 = under_cnt;
        run_one_frame(base, l1, l2);
        checkOutput("st_bit0", 64'(sd_cap[base]), 64'd0);
        checkOutput("st_left", cap_bits(base + 1, 32, 1'b0), 64'h0000_0000_A5F0_0F00);
        checkOutput("st_right", cap_bits(base + 33, 31, 1'b0), 64'(24'h123456) << 7);
        checkOutput("st_ws", cap_bits(base, 64, 1'b1), 64'h0000_0000_FFFF_FFFF);
        checkOutput("st_level_l", 64'(l1), 64'd1);
        checkOutput("st_level_r", 64'(l2), 64'd0);
        checkOutput("st_no_underrun", 64'(under_cnt - u0), 64'd0);
        check_idle("st_end");

        $display("[TB] mono frame");
        mode = 1'b1;
        applyStimulus(24'h800001);
        u0 = under_cnt;
        run_one_frame(base, l1, l2);
        checkOutput("mono_left", cap_bits(base + 1, 32, 1'b0), 64'h0000_0000_8000_0100);
        checkOutput("mono_right", cap_bits(base + 33, 31, 1'b0), 64'(24'h800001) << 7);
        checkOutput("mono_level_l", 64'(l1), 64'd0);
        checkOutput("mono_level_r", 64'(l2), 64'd0);
        checkOutput("mono_no_underrun", 64'(under_cnt - u0), 64'd0);

        $display("[TB] stereo underrun on right slot");
        mode = 1'b0;
        applyStimulus(24'hC35A96);
        u0 = under_cnt;
        run_one_frame(base, l1, l2);
        checkOutput("ur_left", cap_bits(base + 1, 32, 1'b0), 64'h0000_0000_C35A_9600);
        checkOutput("ur_right", cap_bits(base + 33, 31, 1'b0), 64'd0);
        checkOutput("ur_pulses", 64'(under_cnt - u0), 64'd1);
        checkOutput("ur_when", 64'(under_rise), 64'(base + 33));

        $display("[TB] backpressure and disable mid-frame");
        a0 = accept_cnt;
        for (int i = 0; i < 4; i++) applyStimulus(words[i]);
        checkOutput("bp_accepted4", 64'(accept_cnt - a0), 64'd4);
        checkOutput("bp_ready_full", 64'(bus.s_ready), 64'd0);
        checkOutput("bp_level_full", 64'(fifo_level), 64'd4);
        bus.s_data  = words[4];
        bus.s_valid = 1'b1;
        a0 = accept_cnt;
        repeat (8) @(negedge clk);
        checkOutput("bp_held", 64'(accept_cnt - a0), 64'd0);
        base = rise_total;
        en   = 1'b1;
        for (int i = 0; i < 2000 && accept_cnt == a0; i++) @(negedge clk);
        bus.s_valid = 1'b0;
        checkOutput("bp_accept5", 64'(accept_cnt - a0), 64'd1);
        checkOutput("bp_after_pop", 64'(accept_rise > base), 64'd1);
        base1 = base + 64;
        wait_rises(base1 + 11);
        en = 1'b0;
        wait_rises(base1 + 64);
        repeat (16) @(negedge clk);
        checkOutput("f0_left", cap_bits(base + 1, 32, 1'b0), 64'(words[0]) << 8);
        checkOutput("f0_right", cap_bits(base + 33, 31, 1'b0), 64'(words[1]) << 7);
        checkOutput("f1_left", cap_bits(base1 + 1, 32, 1'b0), 64'(words[2]) << 8);
        checkOutput("f1_right", cap_bits(base1 + 33, 31, 1'b0), 64'(words[3]) << 7);
        checkOutput("f1_ws", cap_bits(base1, 64, 1'b1), 64'h0000_0000_FFFF_FFFF);
        checkOutput("dis_no_extra_rise", 64'(rise_total), 64'(base1 + 64));
        check_idle("dis_idle");
        checkOutput("dis_level", 64'(fifo_level), 64'd1);
        run_one_frame(base, l1, l2);
        checkOutput("resume_left", cap_bits(base + 1, 32, 1'b0), 64'(words[4]) << 8);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
